serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter that drives the 1-bit serial stream consumed by the team's Mealy sequence-detector / shift-receiver FSMs.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Emits the word as a framed bit stream: start bit, WIDTH data bits MSB-first, stop bit.
- Each bit is held for BIT_CYCLES clocks so slower receivers can sample it.

Parameters:
- WIDTH, 8: data bits per frame; legal range 2..32.
- BIT_CYCLES, 1: clocks per serial bit; legal range 1..256.

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- data_in  input  WIDTH  word to transmit; sampled only on the accept edge.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  transmitter can accept a word; high only in IDLE.
- x_out  output  1  registered serial bit stream; idle level 0.
- busy  output  1  high while a frame is in flight (START, DATA, STOP).
- done  output  1  one-clock pulse when a frame completes.

Behaviour:
- Reset: on a clock edge with reset=1, the next state is IDLE, and x_out=0, busy=0, done=0, load_ready=1. The shift register and counters clear to 0.
- Reset overrides everything, including a mid-frame transfer and a simultaneous load_valid. A partially sent word is discarded and no done pulse is generated.
- States: IDLE, START, DATA, STOP, encoded in 2 bits.
- IDLE:
  - x_out=0, load_ready=1.
  - Accept occurs on an edge with load_valid=1 and load_ready=1: data_in is captured into the shift register, the bit counter is set to WIDTH-1, and the state moves to START.
- START:
  - x_out=1 for BIT_CYCLES clocks, then the state moves to DATA.
- DATA:
  - x_out = shift register MSB.
  - At the end of each bit period, shift left one place with 0 filled in at the LSB, and decrement the bit counter.
  - After the bit period in which the counter equals 0, the state moves to STOP.
  - Exactly WIDTH data bits are sent.
- STOP:
  - x_out=0 for BIT_CYCLES clocks, then the state moves to IDLE.
  - done=1 for exactly one clock: the first clock back in IDLE.
- Bit timer: counts 0..BIT_CYCLES-1 and asserts tick on its last count. It restarts at 0 on accept and on every state change. With BIT_CYCLES=1, tick is high every clock.
- Latency:
  - The first start-bit clock on x_out is the clock after the accept edge.
  - A frame occupies (WIDTH+2)*BIT_CYCLES clocks.
  - load_ready rises together with done.
  - The minimum accept-to-accept spacing is (WIDTH+2)*BIT_CYCLES+1 clocks.
- Edge cases:
  - load_valid held high continuously gives back-to-back frames separated by exactly one idle clock with x_out=0.
  - data_in changes after the accept edge are ignored.
  - load_valid while busy is ignored and nothing is queued.
- Widths:
  - Bit counter width is clog2(WIDTH).
  - Timer width is clog2(BIT_CYCLES), with a minimum of 1.
  - No arithmetic overflow is possible within the legal parameter ranges.

Decomposition:
- Shared package serial_pkg:
  - State encoding localparams: ST_IDLE=2'b00, ST_START=2'b01, ST_DATA=2'b10, ST_STOP=2'b11.
  - Frame constants: START_LEVEL=1, STOP_LEVEL=0, IDLE_LEVEL=0.
  - Default WIDTH and BIT_CYCLES values, also used by the matching receiver.
- Sub-module bit_timer:
  - Parameter BIT_CYCLES.
  - Ports: clock, reset, restart, tick.
  - One instance inside serial_frame_tx.

Test Plan:
- Reset with WIDTH=8, BIT_CYCLES=1: hold reset=1 for 2 clocks, then release -> x_out=0, busy=0, done=0, load_ready=1 on every clock.
- WIDTH=8, BIT_CYCLES=1, accept 8'hA5 -> x_out over the next 10 clocks is 1,1,0,1,0,0,1,0,1,0. busy is high for those 10 clocks, done pulses on clock 11, and load_ready returns on clock 11.
- BIT_CYCLES=3, accept 8'h81 -> each bit is held 3 clocks, giving 30 frame clocks: 111, 111, 000×6, 111, 000. done pulses on clock 31.
- load_valid held high with data_in 8'hFF then 8'h00 -> two frames with exactly one x_out=0 idle clock between them. data_in changed mid-frame to 8'h3C is not transmitted.
- Reset asserted on the 4th data bit of 8'hC3 -> next clock is IDLE with x_out=0, busy=0, and no done pulse. A subsequent accept of 8'h5A transmits cleanly.
- Simultaneous reset=1 and load_valid=1 in IDLE -> no accept occurs, and the state remains IDLE for that clock.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver:
// state encoding, line levels and default frame geometry.
package serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_START = 2'b01,
      ST_DATA  = 2'b10,
      ST_STOP  = 2'b11
   } state_t;

   localparam logic START_LEVEL = 1'b1;
   localparam logic STOP_LEVEL  = 1'b0;
   localparam logic IDLE_LEVEL  = 1'b0;

   localparam int DEFAULT_WIDTH      = 8;
   localparam int DEFAULT_BIT_CYCLES = 1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the last count of each period.
// A restart forces the count back to 0 so a new period begins on the next clock.
module bit_timer
   import serial_pkg::*;
#(
   parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int            TW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);

   logic [TW-1:0] r_count;

   always_ff @(posedge clock) begin
      if (reset || restart) begin
         r_count <= '0;
      end else if (r_count == LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + TW'(1);
      end
   end

   assign tick = (r_count == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits MSB-first,
// stop bit, each held for BIT_CYCLES clocks, with a valid/ready load handshake.
module serial_frame_tx
   import serial_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             x_out,
   output logic             busy,
   output logic             done
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [CW-1:0]    r_bit_cnt;
   logic [CW-1:0]    w_bit_cnt_nxt;
   logic             r_x_out;
   logic             r_busy;
   logic             r_done;
   logic             w_x_nxt;
   logic             w_tick;
   logic             w_restart;

   // Every state change (including the accept) starts a fresh bit period.
   assign w_restart = (w_state_nxt != r_state);

   bit_timer #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_bit_timer (
      .clock  (clock),
      .reset  (reset),
      .restart(w_restart),
      .tick   (w_tick)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      w_x_nxt       = IDLE_LEVEL;

      case (r_state)
         ST_IDLE: begin
            if (load_valid) begin
               w_shift_nxt   = data_in;
               w_bit_cnt_nxt = LAST_BIT;
               w_state_nxt   = ST_START;
            end
         end
         ST_START: begin
            if (w_tick) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
               if (r_bit_cnt == '0) begin
                  w_state_nxt = ST_STOP;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt - CW'(1);
               end
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // x_out is registered, so its level is chosen from the state being entered.
      case (w_state_nxt)
         ST_START: w_x_nxt = START_LEVEL;
         ST_DATA:  w_x_nxt = w_shift_nxt[WIDTH-1];
         ST_STOP:  w_x_nxt = STOP_LEVEL;
         default:  w_x_nxt = IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_x_out   <= IDLE_LEVEL;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_x_out   <= w_x_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_done    <= (r_state == ST_STOP) && w_tick;
      end
   end

   assign load_ready = (r_state == ST_IDLE);
   assign x_out      = r_x_out;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: one instance with single-clock bits and
// one with three-clock bits, checked clock by clock against hand-built frames.
module tb_serial_frame_tx;

   logic       clock;
   logic       reset;
   logic [7:0] data_in;
   logic       lv1, lv3;
   logic       ready1, x1, busy1, done1;
   logic       ready3, x3, busy3, done3;

   int n_checks = 0;
   int n_fail   = 0;

   serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(1)) dut1 (
      .clock     (clock),
      .reset     (reset),
      .data_in   (data_in),
      .load_valid(lv1),
      .load_ready(ready1),
      .x_out     (x1),
      .busy      (busy1),
      .done      (done1)
   );

   serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(3)) dut3 (
      .clock     (clock),
      .reset     (reset),
      .data_in   (data_in),
      .load_valid(lv3),
      .load_ready(ready3),
      .x_out     (x3),
      .busy      (busy3),
      .done      (done3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Checks the 10 frame clocks of dut1, then the done clock (left positioned there).
   task automatic frame_bc1(input string tag, input logic [9:0] f);
      for (int i = 0; i < 10; i++) begin
         chk({tag, "_x"}, 32'(x1), 32'(f[9-i]));
         chk({tag, "_busy"}, 32'(busy1), 32'd1);
         chk({tag, "_ready"}, 32'(ready1), 32'd0);
         chk({tag, "_done_early"}, 32'(done1), 32'd0);
         step();
      end
      chk({tag, "_done"}, 32'(done1), 32'd1);
      chk({tag, "_ready_back"}, 32'(ready1), 32'd1);
      chk({tag, "_x_idle"}, 32'(x1), 32'd0);
      chk({tag, "_busy_end"}, 32'(busy1), 32'd0);
   endtask

   initial begin
      logic [9:0] f;
      reset   = 1'b1;
      lv1     = 1'b0;
      lv3     = 1'b0;
      data_in = 8'h00;

      // reset held two clocks, then two clocks idle
      for (int i = 0; i < 4; i++) begin
         if (i == 2) reset = 1'b0;
         step();
         chk("rst_x", 32'(x1), 32'd0);
         chk("rst_busy", 32'(busy1), 32'd0);
         chk("rst_done", 32'(done1), 32'd0);
         chk("rst_ready", 32'(ready1), 32'd1);
         chk("rst_ready3", 32'(ready3), 32'd1);
      end

      // A5 with one clock per bit
      data_in = 8'hA5;
      lv1 = 1'b1;
      step();
      lv1 = 1'b0;
      data_in = 8'h00;
      frame_bc1("A5", 10'b1101001010);
      step();
      chk("A5_done_pulse_end", 32'(done1), 32'd0);

      // 81 with three clocks per bit
      data_in = 8'h81;
      lv3 = 1'b1;
      step();
      lv3 = 1'b0;
      f = 10'b1100000010;
      for (int j = 0; j < 30; j++) begin
         chk("81_x", 32'(x3), 32'(f[9 - j/3]));
         chk("81_busy", 32'(busy3), 32'd1);
         chk("81_done_early", 32'(done3), 32'd0);
         step();
      end
      chk("81_done", 32'(done3), 32'd1);
      chk("81_ready", 32'(ready3), 32'd1);
      step();
      chk("81_done_end", 32'(done3), 32'd0);

      // load_valid held high: FF then 00, data_in changes during FF ignored
      data_in = 8'hFF;
      lv1 = 1'b1;
      step();
      data_in = 8'h3C;
      frame_bc1("FF", 10'b1111111110);
      data_in = 8'h00;
      step();
      lv1 = 1'b0;
      frame_bc1("00", 10'b1000000000);
      step();

      // reset during the 4th data bit of C3
      data_in = 8'hC3;
      lv1 = 1'b1;
      step();
      lv1 = 1'b0;
      f = 10'b1110000000;
      for (int i = 0; i < 5; i++) begin
         chk("C3_x", 32'(x1), 32'(f[9-i]));
         if (i < 4) step();
      end
      reset = 1'b1;
      step();
      chk("C3_rst_x", 32'(x1), 32'd0);
      chk("C3_rst_busy", 32'(busy1), 32'd0);
      chk("C3_rst_done", 32'(done1), 32'd0);
      chk("C3_rst_ready", 32'(ready1), 32'd1);
      reset = 1'b0;
      step();
      chk("C3_no_done", 32'(done1), 32'd0);
      chk("C3_idle_busy", 32'(busy1), 32'd0);
      data_in = 8'h5A;
      lv1 = 1'b1;
      step();
      lv1 = 1'b0;
      frame_bc1("5A", 10'b1010110100);
      step();

      // reset and load_valid together in IDLE: no accept
      reset = 1'b1;
      lv1 = 1'b1;
      data_in = 8'hFF;
      step();
      chk("rstlv_ready", 32'(ready1), 32'd1);
      chk("rstlv_busy", 32'(busy1), 32'd0);
      chk("rstlv_x", 32'(x1), 32'd0);
      reset = 1'b0;
      lv1 = 1'b0;
      step();
      chk("rstlv_busy_after", 32'(busy1), 32'd0);
      chk("rstlv_x_after", 32'(x1), 32'd0);
      chk("rstlv_ready_after", 32'(ready1), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
